pack_stream_arbiter: RTL and testbench
======================================

// Module: pack_stream_arbiter
// PURPOSE
// Shares one upstream byte link (serial/USB transmitter) between NSRC packet byte sources.
// Each source uses the packet sender's DataNext/DataReady/DataVal pull handshake.
// Grants rotate round-robin and switch only on atomic-unit boundaries (srcLast), so frames
// and sync sequences are never interleaved. Sits between the packet senders and the link handler.
// PARAMETERS
// NSRC       2     number of byte sources (>=2); SW = max(1,$clog2(NSRC))
// POLL_CYC   4     cycles an unlocked poll waits for srcReady before moving to the next source
// STALL_CYC  4096  cycles a locked poll may wait before stalled is flagged
// PORTS
// clk        in   1        system clock; the only clock
// rst        in   1        synchronous, active-high reset
// txNext     in   1        link requests next byte (level)
// txVal      out  8        byte to link; valid while txReady=1
// txReady    out  1        one-cycle pulse: txVal/txSrc valid
// txSrc      out  SW       index of source that supplied txVal
// srcEn      in   NSRC     per-source enable mask; disabled sources are never newly granted
// srcNext    out  NSRC     per-source next-byte request (at most one bit set)
// srcReady   in   NSRC     per-source byte-valid pulse
// srcVal     in   8*NSRC   per-source byte, source i on [8i+7:8i]
// srcLast    in   NSRC     with srcReady: byte ends an atomic unit
// grant      out  SW       currently granted source
// locked     out  1        mid-unit; grant frozen
// stalled    out  1        locked source silent >= STALL_CYC cycles
// BEHAVIOUR
// - Reset: srcNext=0, txReady=0, txVal=0, txSrc=0, grant=0, locked=0, stalled=0, rr=NSRC-1, state IDLE.
// - States: IDLE, ARB, POLL, ABANDON, DONE. waitCnt is cleared on entry to POLL.
// - IDLE: if txNext -> ARB; otherwise stay.
// - ARB (1 cycle): if locked, keep grant -> POLL. Else search rr+1, rr+2, ... (mod NSRC) for the first srcEn bit.
//   If found: grant=rr=that index -> POLL. If none: -> IDLE (retries while txNext held).
// - POLL: srcNext[grant]=1. On srcReady[grant]: txVal<=srcVal[grant], txSrc<=grant,
//   locked<=!srcLast[grant], stalled<=0, srcNext<=0 -> DONE.
//   If unlocked and waitCnt==POLL_CYC-1 with no srcReady: srcNext<=0 -> ABANDON.
//   If locked, wait indefinitely; stalled<=1 when waitCnt reaches STALL_CYC-1 (saturating).
// - ABANDON (1 cycle, srcNext=0): catches a late reply from a registered-response source.
//   On srcReady[grant]: accept it exactly as in POLL -> DONE. Otherwise -> IDLE.
// - DONE: txReady=1 for exactly this cycle, then -> IDLE.
//   Min txNext-to-txReady latency is 4 cycles: IDLE, ARB, POLL(reply), DONE.
//   A new request is sampled no sooner than the cycle after the txReady pulse.
// - txNext is sampled only in IDLE. Once a byte is requested from a source it is always delivered,
//   even if txNext drops.
// - srcReady from a non-granted source is ignored; its byte is dropped (protocol violation).
// - srcReady together with the poll timeout in the same cycle: the byte wins, no abandon.
// - Clearing srcEn for a locked source does not break the unit. It is skipped only at the next ARB with locked=0.
// - rr advances on every unlocked grant, including abandoned polls, so a silent source cannot
//   starve the others.
// - Reset mid-operation: return to the reset state next cycle. Any in-flight source byte is discarded.
// TESTING
// - Reset; srcEn=2'b11; txNext=1; src0 replies 2 cycles after srcNext with 8'hA5, last=1
//   -> txReady pulse with txVal=A5, txSrc=0; the next grant goes to src1.
// - src0 sends a 16-byte unit (last on byte 16) while src1 is also ready
//   -> all 16 txReady carry txSrc=0 and locked=1 until byte 16; byte 17 comes from src1.
// - src1 never replies, src0 always replies
//   -> src1 polled for POLL_CYC=4 cycles then abandoned; src0 is served every other grant.
// - src1 replies in the first ABANDON cycle -> byte forwarded with txSrc=1, nothing lost or duplicated.
// - Locked src0 silent for 4096 cycles -> stalled=1 and grant stays 0;
//   src0 then replies -> stalled=0 and the byte is forwarded.
// - srcEn=0 with txNext=1 -> srcNext stays 0 and no txReady.
//   Assert rst while in POLL -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pack_stream_arbiter.sv
// pack_stream_arbiter
//
// Shares one upstream byte link between NSRC packet byte sources that use the
// DataNext/DataReady/DataVal pull handshake. The grant rotates round-robin and
// moves only when a source finishes an atomic unit (srcLast), so frames and
// sync sequences from different sources never interleave on the link.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   txNext    link asks for the next byte (level, sampled only in IDLE)
//   txVal     byte to the link, valid while txReady is high
//   txReady   one-cycle pulse marking txVal/txSrc valid
//   txSrc     index of the source that supplied txVal
//   srcEn     per-source enable mask; disabled sources are never newly granted
//   srcNext   per-source next-byte request (one-hot or zero)
//   srcReady  per-source byte-valid pulse
//   srcVal    per-source byte, source i on [8i+7:8i]
//   srcLast   qualifies srcReady: this byte closes an atomic unit
//   grant     currently granted source
//   locked    a unit is in progress; grant is frozen
//   stalled   the locked source has been silent for STALL_CYC cycles or more
module pack_stream_arbiter #(
  parameter int NSRC      = 2,
  parameter int POLL_CYC  = 4,
  parameter int STALL_CYC = 4096,
  localparam int SW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              txNext,
  output logic [7:0]        txVal,
  output logic              txReady,
  output logic [SW-1:0]     txSrc,
  input  logic [NSRC-1:0]   srcEn,
  output logic [NSRC-1:0]   srcNext,
  input  logic [NSRC-1:0]   srcReady,
  input  logic [8*NSRC-1:0] srcVal,
  input  logic [NSRC-1:0]   srcLast,
  output logic [SW-1:0]     grant,
  output logic              locked,
  output logic              stalled
);

  localparam int WMAX = (POLL_CYC > STALL_CYC) ? POLL_CYC : STALL_CYC;
  localparam int CW   = $clog2(WMAX + 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_CYC - 1);

  typedef enum logic [2:0] {IDLE, ARB, POLL, ABANDON, DONE} state_t;

  state_t        state;
  logic [SW-1:0] rr;
  logic [CW-1:0] wait_cnt;

  logic          reply;
  logic          reply_last;
  logic [7:0]    reply_val;
  logic          found;
  logic [SW-1:0] pick;

  // Only the granted source's reply is ever looked at; anything else is dropped.
  assign reply      = srcReady[grant];
  assign reply_last = srcLast[grant];
  assign reply_val  = srcVal[{grant, 3'b000} +: 8];

  // Round-robin search starting just after the last unlocked grant.
  always_comb begin
    int cand;
    found = 1'b0;
    pick  = rr;
    cand  = 0;
    for (int i = 1; i <= NSRC; i++) begin
      cand = (int'(rr) + i) % NSRC;
      if (!found && srcEn[SW'(cand)]) begin
        found = 1'b1;
        pick  = SW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= SW'(NSRC - 1);
      wait_cnt <= '0;
      grant    <= '0;
      locked   <= 1'b0;
      stalled  <= 1'b0;
      srcNext  <= '0;
      txVal    <= '0;
      txSrc    <= '0;
      txReady  <= 1'b0;
    end else begin
      txReady <= 1'b0;
      // A reply in POLL or in the one-cycle ABANDON window is always taken,
      // which also makes a reply coinciding with the poll timeout win.
      if ((state == POLL || state == ABANDON) && reply) begin
        txVal   <= reply_val;
        txSrc   <= grant;
        locked  <= !reply_last;
        stalled <= 1'b0;
        srcNext <= '0;
        txReady <= 1'b1;
        state   <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (txNext) state <= ARB;
          end
          ARB: begin
            // rr moves on every unlocked grant, even one that later times out,
            // so a silent source cannot starve the others.
            if (locked) begin
              srcNext  <= NSRC'(1) << grant;
              wait_cnt <= '0;
              state    <= POLL;
            end else if (found) begin
              grant    <= pick;
              rr       <= pick;
              srcNext  <= NSRC'(1) << pick;
              wait_cnt <= '0;
              state    <= POLL;
            end else begin
              state <= IDLE;
            end
          end
          POLL: begin
            if (!locked) begin
              if (wait_cnt == POLL_LAST) begin
                srcNext <= '0;
                state   <= ABANDON;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end else begin
              // Mid-unit the source is waited for indefinitely; the counter
              // saturates and only raises the stalled flag.
              if (wait_cnt == STALL_LAST) stalled <= 1'b1;
              else                        wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ABANDON: state <= IDLE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pack_stream_arbiter.sv
// tb_pack_stream_arbiter
//
// Directed bench for pack_stream_arbiter (NSRC=2, POLL_CYC=4, STALL_CYC=4096).
// Each source is a small behavioural responder: once it sees its srcNext it
// answers after a programmable number of cycles (0 = never), counting cycles
// even after srcNext drops so late replies can be produced.
module tb_pack_stream_arbiter;

  localparam int NSRC = 2;
  localparam int SW   = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              txNext;
  logic [7:0]        txVal;
  logic              txReady;
  logic [SW-1:0]     txSrc;
  logic [NSRC-1:0]   srcEn;
  logic [NSRC-1:0]   srcNext;
  logic [NSRC-1:0]   srcReady;
  logic [8*NSRC-1:0] srcVal;
  logic [NSRC-1:0]   srcLast;
  logic [SW-1:0]     grant;
  logic              locked;
  logic              stalled;

  pack_stream_arbiter #(.NSRC(NSRC), .POLL_CYC(4), .STALL_CYC(4096)) dut (
    .clk(clk), .rst(rst), .txNext(txNext), .txVal(txVal), .txReady(txReady),
    .txSrc(txSrc), .srcEn(srcEn), .srcNext(srcNext), .srcReady(srcReady),
    .srcVal(srcVal), .srcLast(srcLast), .grant(grant), .locked(locked),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source responder model state
  int         dly  [NSRC];
  int         cnt  [NSRC];
  bit         busy [NSRC];
  logic [7:0] nxt  [NSRC];
  int         ulen [NSRC];
  int         upos [NSRC];

  // Observations taken at each falling edge
  bit         tx_seen;
  logic [7:0] tx_v;
  logic       tx_s;
  logic       tx_lock;
  int         tx_count;
  int         next1_cycles;
  int         next_any;
  bit         got;
  int         n;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Advance to the next falling edge, record outputs, then drive responders.
  task automatic applyStimulus();
    @(negedge clk);
    tx_seen = txReady;
    tx_v    = txVal;
    tx_s    = txSrc;
    tx_lock = locked;
    if (txReady)      tx_count++;
    if (srcNext[1])   next1_cycles++;
    if (srcNext != 0) next_any++;
    srcReady = '0;
    srcLast  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!busy[i] && srcNext[i] && dly[i] > 0) begin
        busy[i] = 1'b1;
        cnt[i]  = 0;
      end
      if (busy[i]) begin
        cnt[i]++;
        if (cnt[i] == dly[i]) begin
          busy[i]          = 1'b0;
          srcReady[i]      = 1'b1;
          srcVal[8*i +: 8] = nxt[i];
          srcLast[i]       = (upos[i] == ulen[i] - 1);
          nxt[i]           = nxt[i] + 8'd1;
          upos[i]          = srcLast[i] ? 0 : upos[i] + 1;
        end
      end
    end
  endtask

  task automatic waitTx(input int budget, output int cycles);
    cycles = 0;
    got    = 1'b0;
    while (cycles < budget && !got) begin
      applyStimulus();
      cycles++;
      got = tx_seen;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_txReady"}, 32'(txReady), 32'd0);
    checkOutput({tag, "_txVal"},   32'(txVal),   32'd0);
    checkOutput({tag, "_txSrc"},   32'(txSrc),   32'd0);
    checkOutput({tag, "_grant"},   32'(grant),   32'd0);
    checkOutput({tag, "_locked"},  32'(locked),  32'd0);
    checkOutput({tag, "_stalled"}, 32'(stalled), 32'd0);
    checkOutput({tag, "_srcNext"}, 32'(srcNext), 32'd0);
  endtask

  initial begin
    rst = 1'b1; txNext = 1'b0; srcEn = '0;
    srcReady = '0; srcVal = '0; srcLast = '0;
    tx_count = 0; next1_cycles = 0; next_any = 0;
    for (int i = 0; i < NSRC; i++) begin
      dly[i] = 0; cnt[i] = 0; busy[i] = 1'b0; nxt[i] = 8'h00; ulen[i] = 1; upos[i] = 0;
    end
    applyStimulus();
    applyStimulus();
    checkReset("reset");

    // Single-byte units from both sources, reply two cycles into the poll
    $display("[TB] single bytes and rotation");
    srcEn = 2'b11; dly[0] = 2; dly[1] = 2; nxt[0] = 8'hA5; nxt[1] = 8'h5A;
    rst = 1'b0; txNext = 1'b1;
    waitTx(20, n);
    checkOutput("t1_got",     32'(got),  32'd1);
    checkOutput("t1_latency", 32'(n),    32'd4);
    checkOutput("t1_val",     32'(tx_v), 32'hA5);
    checkOutput("t1_src",     32'(tx_s), 32'd0);
    waitTx(20, n);
    checkOutput("t1b_got", 32'(got),  32'd1);
    checkOutput("t1b_gap", 32'(n),    32'd5);
    checkOutput("t1b_val", 32'(tx_v), 32'h5A);
    checkOutput("t1b_src", 32'(tx_s), 32'd1);

    // 16-byte unit from src0 must not be interrupted by src1
    $display("[TB] locked 16-byte unit");
    dly[0] = 1; dly[1] = 1; nxt[0] = 8'h10; ulen[0] = 16; nxt[1] = 8'h80;
    next1_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      waitTx(20, n);
      checkOutput("t2_got",    32'(got),     32'd1);
      checkOutput("t2_src",    32'(tx_s),    32'd0);
      checkOutput("t2_val",    32'(tx_v),    32'(8'(8'h10 + k)));
      checkOutput("t2_locked", 32'(tx_lock), 32'(k != 15));
    end
    checkOutput("t2_src1_idle", 32'(next1_cycles), 32'd0);
    waitTx(20, n);
    checkOutput("t2b_got", 32'(got),  32'd1);
    checkOutput("t2b_src", 32'(tx_s), 32'd1);
    checkOutput("t2b_val", 32'(tx_v), 32'h80);

    // Silent src1 is polled for exactly four cycles between src0 bytes
    $display("[TB] silent source abandoned");
    ulen[0] = 1; nxt[0] = 8'h40; dly[1] = 0;
    waitTx(20, n);
    checkOutput("t3_got", 32'(got),  32'd1);
    checkOutput("t3_src", 32'(tx_s), 32'd0);
    checkOutput("t3_val", 32'(tx_v), 32'h40);
    for (int k = 1; k < 4; k++) begin
      next1_cycles = 0;
      waitTx(30, n);
      checkOutput("t3_got_k",    32'(got),          32'd1);
      checkOutput("t3_src_k",    32'(tx_s),         32'd0);
      checkOutput("t3_val_k",    32'(tx_v),         32'(8'(8'h40 + k)));
      checkOutput("t3_poll_len", 32'(next1_cycles), 32'd4);
    end

    // Late reply in ABANDON, then reply coinciding with the timeout
    $display("[TB] late replies");
    dly[1] = 5; nxt[1] = 8'hC3;
    waitTx(30, n);
    checkOutput("t4_got", 32'(got),  32'd1);
    checkOutput("t4_src", 32'(tx_s), 32'd1);
    checkOutput("t4_val", 32'(tx_v), 32'hC3);
    waitTx(30, n);
    checkOutput("t4b_src", 32'(tx_s), 32'd0);
    checkOutput("t4b_val", 32'(tx_v), 32'h44);
    waitTx(30, n);
    checkOutput("t4c_src", 32'(tx_s), 32'd1);
    checkOutput("t4c_val", 32'(tx_v), 32'hC4);
    dly[1] = 4;
    waitTx(30, n);
    checkOutput("t4d_src", 32'(tx_s), 32'd0);
    checkOutput("t4d_val", 32'(tx_v), 32'h45);
    waitTx(30, n);
    checkOutput("t4e_got", 32'(got),  32'd1);
    checkOutput("t4e_src", 32'(tx_s), 32'd1);
    checkOutput("t4e_val", 32'(tx_v), 32'hC5);

    // Locked src0 goes silent long enough to raise stalled
    $display("[TB] stall on locked source");
    nxt[0] = 8'h60; ulen[0] = 2; dly[0] = 1;
    waitTx(20, n);
    checkOutput("t5_src",    32'(tx_s),    32'd0);
    checkOutput("t5_val",    32'(tx_v),    32'h60);
    checkOutput("t5_locked", 32'(tx_lock), 32'd1);
    dly[0] = 0;
    repeat (4097) applyStimulus();
    checkOutput("t5_not_stalled", 32'(stalled), 32'd0);
    checkOutput("t5_srcNext",     32'(srcNext), 32'd1);
    repeat (3) applyStimulus();
    checkOutput("t5_stalled", 32'(stalled), 32'd1);
    checkOutput("t5_grant",   32'(grant),   32'd0);
    dly[0] = 1;
    waitTx(20, n);
    checkOutput("t5b_got",     32'(got),     32'd1);
    checkOutput("t5b_src",     32'(tx_s),    32'd0);
    checkOutput("t5b_val",     32'(tx_v),    32'h61);
    checkOutput("t5b_stalled", 32'(stalled), 32'd0);
    checkOutput("t5b_locked",  32'(tx_lock), 32'd0);

    // Nothing enabled: no requests, no bytes
    $display("[TB] all sources disabled");
    srcEn = 2'b00; next_any = 0; tx_count = 0;
    repeat (20) applyStimulus();
    checkOutput("t6_srcNext", 32'(next_any), 32'd0);
    checkOutput("t6_txReady", 32'(tx_count), 32'd0);

    // Reset while polling, then restart from src0
    $display("[TB] reset during poll");
    srcEn = 2'b11; dly[0] = 0; dly[1] = 0;
    n = 0;
    while (srcNext == 0 && n < 10) begin
      applyStimulus();
      n++;
    end
    checkOutput("t7_in_poll", 32'(srcNext != 0), 32'd1);
    rst = 1'b1;
    applyStimulus();
    checkReset("t7_reset");
    rst = 1'b0; dly[0] = 1; dly[1] = 1; nxt[0] = 8'h77; nxt[1] = 8'h88;
    ulen[0] = 1; ulen[1] = 1; upos[0] = 0; upos[1] = 0;
    waitTx(20, n);
    checkOutput("t7_got",     32'(got),  32'd1);
    checkOutput("t7_latency", 32'(n),    32'd3);
    checkOutput("t7_src",     32'(tx_s), 32'd0);
    checkOutput("t7_val",     32'(tx_v), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
